// File: rtl/sample_stats.sv
`default_nettype none
// ============================================================================
// Module      : sample_stats
// Description : Per-channel windowed statistics (fraction over threshold,
//               mean in 1/32 LSB). Define SAMPLE_STATS_PEAK_EN for peak |x|.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_stats #(
   parameter int NCH      = 4,
   parameter int SW       = 8,
   parameter int WIN_LOG2 = 19,
   parameter int THR      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                x_valid,
   input  logic [NCH*SW-1:0]   x,
   input  logic                clear,
   output logic [NCH*8-1:0]    hi_frac,
   output logic [NCH*8-1:0]    dc,
`ifdef SAMPLE_STATS_PEAK_EN
   output logic [NCH*SW-1:0]   peak,
`endif
   output logic                out_valid
);

   localparam int                  c_acc_w   = SW + WIN_LOG2;
   localparam int                  c_hit_w   = WIN_LOG2 + 1;
   localparam logic [WIN_LOG2-1:0] c_last_n  = '1;
   localparam logic [SW-1:0]       c_smin    = {1'b1, {(SW-1){1'b0}}};
   localparam logic [SW-1:0]       c_mag_max = {1'b0, {(SW-1){1'b1}}};
   localparam logic [SW-1:0]       c_thr     = SW'(THR);

   logic [WIN_LOG2-1:0] r_n;
   logic                w_accept;
   logic                w_last;

   assign w_accept = x_valid & ~clear;
   assign w_last   = w_accept && (r_n == c_last_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= w_last;
         if (clear || w_last)
            r_n <= '0;
         else if (x_valid)
            r_n <= r_n + 1'b1;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [SW-1:0]      w_s;
      logic [SW-1:0]      w_mag;
      logic               w_hit;
      logic [c_hit_w-1:0] r_hits;
      logic [c_hit_w-1:0] w_hits_fin;
      logic [c_hit_w-1:0] w_hits_shr;
      logic [7:0]         w_hi;
      logic [c_acc_w-1:0] r_acc;
      logic [c_acc_w-1:0] w_acc_fin;
      logic [7:0]         w_dc;
      logic [7:0]         r_hi;
      logic [7:0]         r_dc;

      assign w_s = x[k*SW +: SW];

      // Saturating magnitude: the most negative code has no positive twin
      always_comb begin
         w_mag = w_s;
         if (w_s == c_smin)
            w_mag = c_mag_max;
         else if (w_s[SW-1])
            w_mag = ~w_s + 1'b1;
      end

      assign w_hit      = (w_mag >= c_thr);
      assign w_hits_fin = r_hits + {{(c_hit_w-1){1'b0}}, w_hit};
      assign w_hits_shr = w_hits_fin >> (WIN_LOG2 - 8);
      assign w_hi       = (|w_hits_shr[c_hit_w-1:8]) ? 8'hFF : w_hits_shr[7:0];
      assign w_acc_fin  = r_acc + {{WIN_LOG2{w_s[SW-1]}}, w_s};

      if (SW >= 3) begin : g_dc_wide
         assign w_dc = w_acc_fin[WIN_LOG2+2 -: 8];
      end else begin : g_dc_narrow
         assign w_dc = {w_acc_fin[c_acc_w-1], w_acc_fin[WIN_LOG2+1 -: 7]};
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_hits <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_dc   <= '0;
         end else if (clear || w_last) begin
            r_hits <= '0;
            r_acc  <= '0;
            if (w_last) begin
               r_hi <= w_hi;
               r_dc <= w_dc;
            end
         end else if (x_valid) begin
            r_hits <= w_hits_fin;
            r_acc  <= w_acc_fin;
         end
      end

      assign hi_frac[k*8 +: 8] = r_hi;
      assign dc[k*8 +: 8]      = r_dc;

`ifdef SAMPLE_STATS_PEAK_EN
      logic [SW-1:0] r_run_max;
      logic [SW-1:0] w_max_fin;
      logic [SW-1:0] r_peak;

      assign w_max_fin = (w_mag > r_run_max) ? w_mag : r_run_max;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_run_max <= '0;
            r_peak    <= '0;
         end else if (clear || w_last) begin
            r_run_max <= '0;
            if (w_last)
               r_peak <= w_max_fin;
         end else if (x_valid) begin
            r_run_max <= w_max_fin;
         end
      end

      assign peak[k*SW +: SW] = r_peak;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_sample_stats.sv
`default_nettype none
// Testbench for sample_stats: random and directed stimulus checked every
// cycle against a window-level arithmetic model, plus literal pins.
module tb_sample_stats;

   localparam int NCH = 2;
   localparam int SW  = 8;
   localparam int WL  = 8;
   localparam int THR = 16;
   localparam int WIN = 1 << WL;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              x_valid = 1'b0;
   logic [NCH*SW-1:0] x = '0;
   logic              clear = 1'b0;
   logic [NCH*8-1:0]  hi_frac;
   logic [NCH*8-1:0]  dc;
`ifdef SAMPLE_STATS_PEAK_EN
   logic [NCH*SW-1:0] peak;
`endif
   logic              out_valid;

   int n_checks = 0;
   int n_errors = 0;

   sample_stats #(.NCH(NCH), .SW(SW), .WIN_LOG2(WL), .THR(THR)) dut (
      .clk(clk),
      .rst(rst),
      .x_valid(x_valid),
      .x(x),
      .clear(clear),
      .hi_frac(hi_frac),
      .dc(dc),
`ifdef SAMPLE_STATS_PEAK_EN
      .peak(peak),
`endif
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   // Window model: plain integer sums, hit counts and maxima over accepted samples
   int m_cnt;
   int m_sum [NCH];
   int m_hits[NCH];
   int m_max [NCH];
   int e_hi  [NCH];
   int e_dc  [NCH];
   int e_pk  [NCH];
   bit e_v;

   function automatic int sval(logic [SW-1:0] b);
      logic signed [SW-1:0] t;
      t = b;
      return int'(t);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0;
         e_v   = 0;
         for (int k = 0; k < NCH; k++) begin
            m_sum[k] = 0; m_hits[k] = 0; m_max[k] = 0;
            e_hi[k] = 0; e_dc[k] = 0; e_pk[k] = 0;
         end
      end else begin
         e_v = 0;
         if (clear) begin
            m_cnt = 0;
            for (int k = 0; k < NCH; k++) begin
               m_sum[k] = 0; m_hits[k] = 0; m_max[k] = 0;
            end
         end else if (x_valid) begin
            m_cnt++;
            for (int k = 0; k < NCH; k++) begin
               int s, mag;
               s   = sval(x[k*SW +: SW]);
               mag = (s == -(1 << (SW-1))) ? (1 << (SW-1)) - 1 : (s < 0 ? -s : s);
               m_sum[k] += s;
               if (mag >= THR) m_hits[k]++;
               if (mag > m_max[k]) m_max[k] = mag;
            end
            if (m_cnt == WIN) begin
               e_v = 1;
               for (int k = 0; k < NCH; k++) begin
                  int h;
                  h = m_hits[k] >> (WL - 8);
                  e_hi[k] = (h > 255) ? 255 : h;
                  e_dc[k] = (m_sum[k] >>> (WL - 5)) & 255;
                  e_pk[k] = m_max[k];
                  m_sum[k] = 0; m_hits[k] = 0; m_max[k] = 0;
               end
               m_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("out_valid", int'(out_valid), int'(e_v));
      for (int k = 0; k < NCH; k++) begin
         chk($sformatf("hi_frac[%0d]", k), int'(hi_frac[k*8 +: 8]), e_hi[k]);
         chk($sformatf("dc[%0d]", k), int'(dc[k*8 +: 8]), e_dc[k]);
`ifdef SAMPLE_STATS_PEAK_EN
         chk($sformatf("peak[%0d]", k), int'(peak[k*SW +: SW]), e_pk[k]);
`endif
      end
   end

   task automatic cyc(input bit v, input logic [7:0] a, input logic [7:0] b, input bit clr);
      x_valid = v;
      x       = {b, a};
      clear   = clr;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rnd_sample();
      case ($urandom_range(0, 7))
         0: return 8'h80;
         1: return 8'h7F;
         2: return 8'h10;
         3: return 8'hF0;
         4: return 8'h0F;
         5: return 8'hF1;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      logic [15:0] held_hi, held_dc;

      repeat (3) cyc(0, 8'h00, 8'h00, 0);
      rst = 1'b0;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset hi_frac", int'(hi_frac), 0);
      chk("reset dc", int'(dc), 0);

      // Constant +20 / -3, continuous valid
      for (int i = 0; i < WIN; i++) cyc(1, 8'd20, 8'hFD, 0);
      chk("const strobe", int'(out_valid), 1);
      chk("const hi_frac", int'(hi_frac), 16'h00FF);
      chk("const dc", int'(dc), 16'hA080);

      // Same samples, valid every other cycle
      for (int i = 0; i < 2*WIN - 1; i++) cyc(i % 2 == 0, 8'd20, 8'hFD, 0);
      chk("gap strobe", int'(out_valid), 1);
      chk("gap hi_frac", int'(hi_frac), 16'h00FF);
      chk("gap dc", int'(dc), 16'hA080);
      held_hi = hi_frac;
      held_dc = dc;
      cyc(0, 8'd20, 8'hFD, 0);
      chk("gap strobe low", int'(out_valid), 0);
      chk("gap hi held", int'(hi_frac), int'(held_hi));
      chk("gap dc held", int'(dc), int'(held_dc));

      // Alternating +16 / -128 on ch0: every sample crosses the threshold
      for (int i = 0; i < WIN; i++) cyc(1, (i % 2 == 0) ? 8'h10 : 8'h80, rnd_sample(), 0);
      chk("alt strobe", int'(out_valid), 1);
      chk("alt hi_frac0", int'(hi_frac[7:0]), 255);

      // clear mid-window and on the would-be last sample
      for (int i = 0; i < 200; i++) cyc(1, rnd_sample(), rnd_sample(), 0);
      cyc(1, rnd_sample(), rnd_sample(), 1);
      for (int i = 0; i < WIN - 1; i++) cyc(1, rnd_sample(), rnd_sample(), 0);
      cyc(1, rnd_sample(), rnd_sample(), 1);
      chk("clear-last no strobe", int'(out_valid), 0);
      for (int i = 0; i < WIN - 1; i++) cyc(1, rnd_sample(), rnd_sample(), 0);
      chk("clear pre strobe", int'(out_valid), 0);
      cyc(1, rnd_sample(), rnd_sample(), 0);
      chk("clear post strobe", int'(out_valid), 1);

      // rst mid-window
      for (int i = 0; i < 100; i++) cyc(1, rnd_sample(), rnd_sample(), 0);
      rst = 1'b1;
      cyc(1, rnd_sample(), rnd_sample(), 0);
      rst = 1'b0;
      chk("rst hi_frac", int'(hi_frac), 0);
      chk("rst dc", int'(dc), 0);
      for (int i = 0; i < WIN; i++) cyc(1, rnd_sample(), rnd_sample(), 0);
      chk("rst window strobe", int'(out_valid), 1);

      // Ramp ending on the most negative code
      for (int i = 0; i < WIN - 1; i++) cyc(1, 8'(i), 8'(WIN - 1 - i), 0);
      cyc(1, 8'h80, 8'h00, 0);
      chk("ramp strobe", int'(out_valid), 1);
`ifdef SAMPLE_STATS_PEAK_EN
      chk("ramp peak0", int'(peak[7:0]), 127);
`endif

      // Random traffic with gaps and occasional clear
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(), $urandom_range(0, 499) == 0);
      repeat (2) cyc(0, 8'h00, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
